// File: rtl/address_sequencer.sv
// -----------------------------------------------------------------------------
// address_sequencer
//
// Drives the configuration of an external address generator through one
// sequence: IDLE -> LOAD (generator held in load for LOAD_CYCLES clocks) ->
// RUN (generator running, wrap pulses counted) -> DONE (one-cycle completion
// pulse) -> IDLE.  A stop request aborts LOAD/RUN without a done pulse.
// All outputs are registered.
//
// Parameters
//   LOAD_CYCLES  clocks spent in LOAD before RUN (1..255)
//   CNT_WIDTH    width of n_cycles and cycle_count
//
// Ports
//   clk          clock, rising edge active
//   resetn       asynchronous active-low reset
//   start        begin a sequence (accepted only in IDLE without stop)
//   stop         abort request (LOAD/RUN), also blocks start in IDLE
//   continuous   1 = run until stop (sampled on accepted start)
//   period_in    generator period (sampled on accepted start)
//   n_cycles     generator periods to run, 0 treated as 1 (sampled on start)
//   restart      one-cycle wrap pulse from the generator
//   addr_cfg     generator config: 00 idle, 01 load, 11 run
//   addr_period  period driven to the generator
//   busy         high in LOAD and RUN
//   done         one-cycle pulse on normal completion
//   cycle_count  restart pulses counted in the current/last sequence
// -----------------------------------------------------------------------------
module address_sequencer #(
    parameter int LOAD_CYCLES = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [31:0]          period_in,
    input  logic [CNT_WIDTH-1:0] n_cycles,
    input  logic                 restart,
    output logic [1:0]           addr_cfg,
    output logic [31:0]          addr_period,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [1:0] CFG_IDLE = 2'b00;
    localparam logic [1:0] CFG_LOAD = 2'b01;
    localparam logic [1:0] CFG_RUN  = 2'b11;

    // Load counter is preset to LOAD_CYCLES-1 and LOAD exits on the edge it
    // reads zero, giving exactly LOAD_CYCLES cycles of addr_cfg=01.
    localparam logic [7:0]           LOAD_LAST = 8'(LOAD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [1:0]           state_q,  state_d;
    logic [7:0]           ld_cnt_q, ld_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0] nlat_q,   nlat_d;
    logic                 cont_q,   cont_d;
    logic [31:0]          period_q, period_d;
    logic [1:0]           cfg_q,    cfg_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Saturating increment; only reachable at all-ones in continuous mode.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        cnt_d    = cnt_q;
        nlat_d   = nlat_q;
        cont_d   = cont_q;
        period_d = period_q;

        case (state_q)
            S_IDLE: begin
                // stop takes priority over a simultaneous start
                if (start && !stop) begin
                    state_d  = S_LOAD;
                    ld_cnt_d = LOAD_LAST;
                    cnt_d    = '0;
                    nlat_d   = (n_cycles == '0) ? CNT_ONE : n_cycles;
                    cont_d   = continuous;
                    period_d = period_in;
                end
            end
            S_LOAD: begin
                // restart pulses are ignored while the generator is loading
                if (stop) begin
                    state_d = S_IDLE;
                end else if (ld_cnt_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    ld_cnt_d = ld_cnt_q - 8'd1;
                end
            end
            S_RUN: begin
                // the count still advances on an edge where stop wins
                if (restart) begin
                    cnt_d = cnt_inc;
                end
                if (stop) begin
                    state_d = S_IDLE;
                end else if (restart && !cont_q && (cnt_inc == nlat_q)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register.
    always_comb begin
        cfg_d  = CFG_IDLE;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_LOAD: begin
                cfg_d  = CFG_LOAD;
                busy_d = 1'b1;
            end
            S_RUN: begin
                cfg_d  = CFG_RUN;
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cfg_d = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            ld_cnt_q <= 8'd0;
            cnt_q    <= '0;
            nlat_q   <= CNT_ONE;
            cont_q   <= 1'b0;
            period_q <= 32'd0;
            cfg_q    <= CFG_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            cnt_q    <= cnt_d;
            nlat_q   <= nlat_d;
            cont_q   <= cont_d;
            period_q <= period_d;
            cfg_q    <= cfg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign addr_cfg    = cfg_q;
    assign addr_period = period_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_address_sequencer.sv
// -----------------------------------------------------------------------------
// tb_address_sequencer
//
// Directed scenarios followed by randomized stimulus.  A behavioural model
// describes the sequence as "busy / load cycles left / count / done pulse" and
// a compare process checks every DUT output against it on each falling edge.
// Directed scenarios also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_address_sequencer;

    localparam int LC   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic [31:0]   period_in = 32'd0;
    logic [CW-1:0] n_cycles = '0;
    logic          restart = 1'b0;
    logic [1:0]    addr_cfg;
    logic [31:0]   addr_period;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    address_sequencer #(.LOAD_CYCLES(LC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .continuous(continuous), .period_in(period_in), .n_cycles(n_cycles),
        .restart(restart), .addr_cfg(addr_cfg), .addr_period(addr_period),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy, m_done, m_cont;
    int          m_load_left, m_cnt, m_tgt;
    logic [31:0] m_period;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_done = 0; m_cont = 0;
            m_load_left = 0; m_cnt = 0; m_tgt = 1; m_period = 32'd0;
        end else if (m_done) begin
            m_done = 0;                       // completion pulse lasts one cycle
        end else if (!m_busy) begin
            if (start && !stop) begin
                m_period    = period_in;
                m_tgt       = (n_cycles == 0) ? 1 : int'(n_cycles);
                m_cont      = continuous;
                m_cnt       = 0;
                m_busy      = 1;
                m_load_left = LC;
            end
        end else if (m_load_left > 0) begin
            if (stop) begin
                m_busy = 0; m_load_left = 0;
            end else begin
                m_load_left--;
            end
        end else begin
            if (restart && m_cnt < CMAX) m_cnt++;
            if (stop) m_busy = 0;
            else if (!m_cont && restart && m_cnt == m_tgt) begin
                m_busy = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e_cfg;
        e_cfg = m_busy ? ((m_load_left > 0) ? 2'b01 : 2'b11) : 2'b00;
        chk("cfg", 32'(addr_cfg), 32'(e_cfg));
        chk("period", addr_period, m_period);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("count", 32'(cycle_count), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit sp, input bit c,
                         input logic [31:0] p, input logic [CW-1:0] n, input bit r);
        start = s; stop = sp; continuous = c; period_in = p; n_cycles = n; restart = r;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 32'hDEAD, 0, 0);
    endtask

    task automatic pulse_restart();
        drive(0, 0, 0, 32'hDEAD, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        #2;
        chk("rst_cfg", 32'(addr_cfg), 0);
        chk("rst_period", addr_period, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(cycle_count), 0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // period 255, 3 cycles, non-continuous
        drive(1, 0, 0, 255, 3, 0);
        chk("d1_load_lat", 32'(addr_cfg), 1);
        idle(3);
        chk("d1_load_4th", 32'(addr_cfg), 1);
        idle(1);
        chk("d1_run", 32'(addr_cfg), 3);
        pulse_restart(); idle(1); pulse_restart(); idle(1);
        chk("d1_run_cnt2", 32'(cycle_count), 2);
        pulse_restart();
        chk("d1_done", 32'(done), 1);
        chk("d1_count", 32'(cycle_count), 3);
        chk("d1_period", addr_period, 255);
        chk("d1_cfg_idle", 32'(addr_cfg), 0);
        idle(1);
        chk("d1_done_end", 32'(done), 0);

        // n_cycles = 0 behaves as 1
        drive(1, 0, 0, 77, 0, 0);
        idle(4);
        pulse_restart();
        chk("d2_done", 32'(done), 1);
        chk("d2_count", 32'(cycle_count), 1);
        idle(2);

        // restart ignored in LOAD, start ignored in RUN
        drive(1, 0, 0, 255, 4, 0);
        for (int i = 0; i < LC; i++) pulse_restart();
        chk("d3_load_ign", 32'(cycle_count), 0);
        chk("d3_run", 32'(addr_cfg), 3);
        pulse_restart();
        drive(1, 0, 0, 100, 9, 0);
        chk("d3_period_hold", addr_period, 255);
        for (int i = 0; i < 3; i++) begin pulse_restart(); idle(1); end
        chk("d3_count", 32'(cycle_count), 4);
        idle(2);

        // continuous: 10 restarts then stop
        drive(1, 0, 1, 9, 2, 0);
        idle(4);
        for (int i = 0; i < 10; i++) begin pulse_restart(); idle(1); end
        chk("d4_busy", 32'(busy), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("d4_count", 32'(cycle_count), 10);
        chk("d4_cfg", 32'(addr_cfg), 0);
        chk("d4_done", 32'(done), 0);
        idle(2);

        // stop coincident with completing restart
        drive(1, 0, 0, 5, 2, 0);
        idle(4);
        pulse_restart(); idle(1);
        drive(0, 1, 0, 0, 0, 1);
        chk("d5_count", 32'(cycle_count), 2);
        chk("d5_done", 32'(done), 0);
        chk("d5_cfg", 32'(addr_cfg), 0);
        idle(1);
        chk("d5_done_after", 32'(done), 0);

        // start and stop together in IDLE
        drive(1, 1, 0, 11, 3, 0);
        chk("d6_busy", 32'(busy), 0);
        idle(1);

        // saturation in continuous mode
        drive(1, 0, 1, 6, 0, 0);
        idle(4);
        for (int i = 0; i < 20; i++) pulse_restart();
        chk("d7_sat", 32'(cycle_count), CMAX);
        drive(0, 1, 0, 0, 0, 0);
        idle(1);

        // asynchronous reset mid-RUN, then start on the release edge
        drive(1, 0, 0, 42, 5, 0);
        idle(4);
        pulse_restart(); idle(1); pulse_restart(); idle(1);
        chk("d8_cnt_pre", 32'(cycle_count), 2);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("d8_cfg", 32'(addr_cfg), 0);
        chk("d8_period", addr_period, 0);
        chk("d8_busy", 32'(busy), 0);
        chk("d8_count", 32'(cycle_count), 0);
        chk("d8_done", 32'(done), 0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 0, 0, 300, 1, 0);
        chk("d8_restart_load", 32'(addr_cfg), 1);
        idle(4);
        pulse_restart();
        chk("d8_done2", 32'(done), 1);
        chk("d8_count2", 32'(cycle_count), 1);
        idle(2);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0, $urandom,
                  CW'($urandom_range(0, 6)), $urandom_range(0, 2) == 0);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
